clk_div: RTL and testbench

//   Parameterised integer clock divider. Derives a slow, low-duty-jitter

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_counter.sv | 30 +++
 rtl/clk_div.sv | 51 +++++
 tb/tb_clk_div.sv | 126 ++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the integer clock divider.
// Phase lengths and counter width are all derived from the division ratio.
package clk_div_pkg;

    // Clamped to 1 so an illegal DIV still elaborates far enough to report itself.
    function automatic int cnt_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    function automatic int low_phase(input int div);
        return (div + 1) / 2;
    endfunction

    function automatic int high_phase(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Modulo-DIV up counter with synchronous reset.
// Exposes the current count and a flag that marks the last count of a period.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int DIV = 100_000_000,
    parameter int CW  = cnt_width(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign wrap = (cnt == LAST);

    // Returns straight to zero after the last count, so every period is exactly DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div.sv
// Integer clock divider: registered square-wave strobe with a period of DIV clk cycles.
// The low phase is never shorter than the high phase, so odd DIV yields one extra low cycle.
module clk_div
    import clk_div_pkg::*;
#(
    parameter int DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic clkout
);

    localparam int CW = cnt_width(DIV);
    localparam int L  = low_phase(DIV);
    localparam int H  = high_phase(DIV);

    localparam logic [CW-1:0] RISE = CW'(L - 1);

    if (DIV < 2) begin : g_div_check
        $error("clk_div: DIV must be >= 2, got %0d", DIV);
    end

    logic [CW-1:0] cnt;
    logic          wrap;

    clk_div_counter #(
        .DIV (DIV),
        .CW  (CW)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .wrap (wrap)
    );

    // The output is set after L counts and cleared at the wrap, i.e. L + H - 1 == DIV - 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkout <= 1'b0;
        end else if (cnt == RISE) begin
            clkout <= 1'b1;
        end else if (wrap) begin
            clkout <= 1'b0;
        end
    end

    if (L + H != DIV) begin : g_phase_check
        $error("clk_div: phase lengths %0d + %0d do not sum to %0d", L, H, DIV);
    end

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: several DIV values run side by side off one clock.
// Expected waveforms are hand-derived from the rise/fall edge numbering.
module tb_clk_div;

    logic clk;
    logic rst;
    logic rst_5;
    logic clkout_4;
    logic clkout_3;
    logic clkout_2;
    logic clkout_5;
    logic clkout_1000;
    logic clkout_def;

    int tests_run;
    int tests_failed;

    clk_div #(.DIV(4))    dut_4    (.clk(clk), .rst(rst),   .clkout(clkout_4));
    clk_div #(.DIV(3))    dut_3    (.clk(clk), .rst(rst),   .clkout(clkout_3));
    clk_div #(.DIV(2))    dut_2    (.clk(clk), .rst(rst),   .clkout(clkout_2));
    clk_div #(.DIV(5))    dut_5    (.clk(clk), .rst(rst_5), .clkout(clkout_5));
    clk_div #(.DIV(1000)) dut_1000 (.clk(clk), .rst(rst),   .clkout(clkout_1000));
    clk_div               dut_def  (.clk(clk), .rst(rst),   .clkout(clkout_def));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive the resets, then sample 1 ns after the following rising edge.
    task automatic apply_stimulus(input logic r, input logic r5);
        rst   = r;
        rst_5 = r5;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Values after edges k = 1.. following reset release, hand-derived.
        logic [0:7] exp_4;
        logic [0:5] exp_3;
        logic [0:5] exp_2;
        logic [0:7] exp_5;
        logic [0:4] exp_5_restart;
        int         rise_k[0:15];
        int         rise_cnt;
        int         max_cnt;
        logic       prev_1000;
        logic       def_seen_high;

        exp_4         = 8'b0110_0110;
        exp_3         = 6'b010_010;
        exp_2         = 6'b101_010;
        exp_5         = 8'b0011_0001;
        exp_5_restart = 5'b00110;
        tests_run     = 0;
        tests_failed  = 0;
        rise_cnt      = 0;
        max_cnt       = 0;
        prev_1000     = 1'b0;
        def_seen_high = 1'b0;
        rst           = 1'b1;
        rst_5         = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b1);
            check_output($sformatf("reset_div4_%0d", i), int'(clkout_4), 0);
            check_output($sformatf("reset_div3_%0d", i), int'(clkout_3), 0);
            check_output($sformatf("reset_div5_%0d", i), int'(clkout_5), 0);
        end

        for (int k = 1; k <= 10000; k++) begin
            apply_stimulus(1'b0, (k == 9) ? 1'b1 : 1'b0);

            if (k <= 8) begin
                check_output($sformatf("div4_k%0d", k), int'(clkout_4), int'(exp_4[k-1]));
                check_output($sformatf("div5_k%0d", k), int'(clkout_5), int'(exp_5[k-1]));
            end
            if (k <= 6) begin
                check_output($sformatf("div3_k%0d", k), int'(clkout_3), int'(exp_3[k-1]));
                check_output($sformatf("div2_k%0d", k), int'(clkout_2), int'(exp_2[k-1]));
            end
            if (k == 9) begin
                check_output("div5_midreset", int'(clkout_5), 0);
            end
            if (k >= 10 && k <= 14) begin
                check_output($sformatf("div5_restart_k%0d", k - 9), int'(clkout_5),
                             int'(exp_5_restart[k-10]));
            end

            if (clkout_1000 && !prev_1000) begin
                if (rise_cnt < 16) begin
                    rise_k[rise_cnt] = k;
                end
                rise_cnt++;
            end
            prev_1000 = clkout_1000;
            if (int'(dut_1000.u_counter.cnt) > max_cnt) begin
                max_cnt = int'(dut_1000.u_counter.cnt);
            end
            if (clkout_def !== 1'b0) begin
                def_seen_high = 1'b1;
            end
        end

        check_output("div1000_rise_count", rise_cnt, 10);
        for (int i = 0; i < 10; i++) begin
            if (i < rise_cnt) begin
                check_output($sformatf("div1000_rise_%0d", i), rise_k[i], 500 + 1000 * i);
            end
        end
        check_output("div1000_max_cnt", max_cnt, 999);
        check_output("div4_k10000", int'(clkout_4), 0);
        check_output("default_stays_low", int'(def_seen_high), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
